// File: rtl/ping_pong_pkg.sv
// Encodings and defaults shared by the ping-pong game blocks.
package ping_pong_pkg;

  localparam logic [1:0] ST_SERVE = 2'd0;
  localparam logic [1:0] ST_PLAY  = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;
  localparam logic [1:0] ST_POINT = 2'd3;

  localparam logic [1:0] WIN_NONE = 2'd0;
  localparam logic [1:0] WIN_P1   = 2'd1;
  localparam logic [1:0] WIN_P2   = 2'd2;
  localparam logic [1:0] WIN_TIE  = 2'd3;

  localparam int unsigned DEF_WIN_SCORE     = 7;
  localparam int unsigned DEF_MATCH_SECONDS = 60;

  // Result of a finished match from the two scores.
  function automatic logic [1:0] pick_winner(input logic [3:0] a, input logic [3:0] b);
    if (a > b) return WIN_P1;
    if (a < b) return WIN_P2;
    return WIN_TIE;
  endfunction

endpackage

// File: rtl/button_press_sync.sv
// Two-flop synchroniser for an active-low button plus a press (falling-edge) detector.
module button_press_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic pin,
  output logic press_c
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta   <= 1'b1;
      sync   <= 1'b1;
      sync_d <= 1'b1;
    end else begin
      meta   <= pin;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign press_c = sync_d & ~sync;

endmodule

// File: rtl/match_controller.sv
// Match sequencer: serve/play/point/done FSM, scores, serve ownership and countdown timer.
// Optional macro MATCH_AUTO_SERVE_EN: serve automatically after SERVE_TIMEOUT idle ticks.
module match_controller
  import ping_pong_pkg::*;
#(
  parameter int unsigned TICK_DIV      = 50000000,
  parameter int unsigned MATCH_SECONDS = DEF_MATCH_SECONDS,
  parameter int unsigned WIN_SCORE     = DEF_WIN_SCORE,
  parameter int unsigned PAUSE_TICKS   = 2,
  parameter int unsigned SERVE_TIMEOUT = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       p1l,
  input  logic       p1r,
  input  logic       p2l,
  input  logic       p2r,
  input  logic       ball_out_left,
  input  logic       ball_out_right,
  output logic [1:0] game_state,
  output logic       server,
  output logic       serve_go,
  output logic [3:0] p1_score,
  output logic [3:0] p2_score,
  output logic [5:0] time_cnt,
  output logic [1:0] winner
);

  localparam int unsigned TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int unsigned PH_MAX = (PAUSE_TICKS > SERVE_TIMEOUT) ? PAUSE_TICKS : SERVE_TIMEOUT;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

  logic [3:0]        press_c;
  logic [TICK_W-1:0] tick_cnt, tick_cnt_n;
  logic [PH_W-1:0]   phase_cnt, phase_cnt_n;
  logic [1:0]        state_n, winner_n;
  logic              server_n, go_n;
  logic [3:0]        p1_n, p2_n;
  logic [5:0]        time_n;
  logic              running_c, tick_c, serve_req_c, timeout_c;

  button_press_sync u_p1l (.clk(clk), .rst_n(reset), .pin(p1l), .press_c(press_c[0]));
  button_press_sync u_p1r (.clk(clk), .rst_n(reset), .pin(p1r), .press_c(press_c[1]));
  button_press_sync u_p2l (.clk(clk), .rst_n(reset), .pin(p2l), .press_c(press_c[2]));
  button_press_sync u_p2r (.clk(clk), .rst_n(reset), .pin(p2r), .press_c(press_c[3]));

`ifdef MATCH_AUTO_SERVE_EN
  assign running_c = (game_state != ST_DONE);
  assign timeout_c = tick_c && (game_state == ST_SERVE) &&
                     (phase_cnt == PH_W'(SERVE_TIMEOUT - 1));
`else
  assign running_c = (game_state == ST_PLAY) || (game_state == ST_POINT);
  assign timeout_c = 1'b0;
`endif

  assign tick_c      = running_c && (tick_cnt == TICK_W'(TICK_DIV - 1));
  assign serve_req_c = server ? (press_c[2] | press_c[3]) : (press_c[0] | press_c[1]);

  // Next-state and next-output logic.
  always_comb begin
    state_n  = game_state;
    server_n = server;
    go_n     = 1'b0;
    p1_n     = p1_score;
    p2_n     = p2_score;
    time_n   = time_cnt;
    winner_n = winner;

    case (game_state)
      ST_SERVE: begin
        if (serve_req_c || timeout_c) begin
          go_n    = 1'b1;
          state_n = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (tick_c && time_cnt != 6'd0) time_n = time_cnt - 6'd1;
        if (ball_out_right && !ball_out_left) begin
          if (p1_score < 4'(WIN_SCORE)) p1_n = p1_score + 4'd1;
          server_n = 1'b1;
          state_n  = (p1_n == 4'(WIN_SCORE)) ? ST_DONE : ST_POINT;
        end else if (ball_out_left && !ball_out_right) begin
          if (p2_score < 4'(WIN_SCORE)) p2_n = p2_score + 4'd1;
          server_n = 1'b0;
          state_n  = (p2_n == 4'(WIN_SCORE)) ? ST_DONE : ST_POINT;
        end
        // A simultaneous score is already in p1_n/p2_n before the time-out ends the match.
        if (tick_c && time_n == 6'd0) state_n = ST_DONE;
      end
      ST_POINT: begin
        if (tick_c && phase_cnt == PH_W'(PAUSE_TICKS - 1)) state_n = ST_SERVE;
      end
      default: ;
    endcase

    if (state_n == ST_DONE && game_state != ST_DONE) winner_n = pick_winner(p1_n, p2_n);

    if (!running_c || state_n != game_state || tick_c) tick_cnt_n = '0;
    else tick_cnt_n = tick_cnt + TICK_W'(1);

    // Ticks spent in SERVE/POINT; restarts on every state change.
    if (state_n != game_state) phase_cnt_n = '0;
    else if (tick_c && game_state != ST_PLAY) phase_cnt_n = phase_cnt + PH_W'(1);
    else phase_cnt_n = phase_cnt;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      game_state <= ST_SERVE;
      server     <= 1'b0;
      serve_go   <= 1'b0;
      p1_score   <= 4'd0;
      p2_score   <= 4'd0;
      time_cnt   <= 6'(MATCH_SECONDS);
      winner     <= WIN_NONE;
      tick_cnt   <= '0;
      phase_cnt  <= '0;
    end else begin
      game_state <= state_n;
      server     <= server_n;
      serve_go   <= go_n;
      p1_score   <= p1_n;
      p2_score   <= p2_n;
      time_cnt   <= time_n;
      winner     <= winner_n;
      tick_cnt   <= tick_cnt_n;
      phase_cnt  <= phase_cnt_n;
    end
  end

endmodule

// File: tb/tb_match_controller.sv
// Bench for match_controller: directed vector table, hand sequences and a random run against a model.
module tb_match_controller;

  localparam int unsigned TD = 4;
  localparam int unsigned MS = 5;
  localparam int unsigned WS = 3;
  localparam int unsigned PT = 2;
  localparam int unsigned SO = 5;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       p1l = 1'b1, p1r = 1'b1, p2l = 1'b1, p2r = 1'b1;
  logic       ball_out_left = 1'b0, ball_out_right = 1'b0;
  logic [1:0] game_state;
  logic       server;
  logic       serve_go;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [5:0] time_cnt;
  logic [1:0] winner;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  match_controller #(
    .TICK_DIV(TD), .MATCH_SECONDS(MS), .WIN_SCORE(WS), .PAUSE_TICKS(PT), .SERVE_TIMEOUT(SO)
  ) dut (
    .clk(clk), .reset(reset),
    .p1l(p1l), .p1r(p1r), .p2l(p2l), .p2r(p2r),
    .ball_out_left(ball_out_left), .ball_out_right(ball_out_right),
    .game_state(game_state), .server(server), .serve_go(serve_go),
    .p1_score(p1_score), .p2_score(p2_score), .time_cnt(time_cnt), .winner(winner)
  );

  // Behavioural reference: cycles-in-state bookkeeping and a pin history per button.
  int m_st, m_srv, m_go, m_p1, m_p2, m_tm, m_win, m_cyc;
  logic [2:0] hist [4];

  always @(posedge clk or negedge reset) begin
    logic [3:0] pins;
    logic [3:0] pr;
    int  ns;
    bit  tick, want;
    if (!reset) begin
      m_st = 0; m_srv = 0; m_go = 0; m_p1 = 0; m_p2 = 0; m_tm = MS; m_win = 0; m_cyc = 0;
      for (int i = 0; i < 4; i++) hist[i] = 3'b111;
    end else begin
      pins = {p1l, p1r, p2l, p2r};
      for (int i = 0; i < 4; i++) begin
        pr[i]   = hist[i][2] & ~hist[i][1];
        hist[i] = {hist[i][1:0], pins[i]};
      end
      ns   = m_st;
      m_go = 0;
      tick = ((m_cyc + 1) % TD) == 0;
      case (m_st)
        0: begin
          want = (m_srv == 0) ? (pr[3] | pr[2]) : (pr[1] | pr[0]);
`ifdef MATCH_AUTO_SERVE_EN
          if ((m_cyc + 1) == int'(SO * TD)) want = 1'b1;
`endif
          if (want) begin m_go = 1; ns = 1; end
        end
        1: begin
          if (tick && m_tm > 0) m_tm = m_tm - 1;
          if (ball_out_right && !ball_out_left) begin
            m_p1 = m_p1 + 1; m_srv = 1; ns = (m_p1 >= int'(WS)) ? 2 : 3;
          end else if (ball_out_left && !ball_out_right) begin
            m_p2 = m_p2 + 1; m_srv = 0; ns = (m_p2 >= int'(WS)) ? 2 : 3;
          end
          if (tick && m_tm == 0) ns = 2;
          if (ns == 2) m_win = (m_p1 > m_p2) ? 1 : (m_p1 < m_p2) ? 2 : 3;
        end
        3: if ((m_cyc + 1) == int'(PT * TD)) ns = 0;
        default: ;
      endcase
      m_cyc = (ns != m_st) ? 0 : m_cyc + 1;
      m_st  = ns;
    end
  end

  typedef struct {
    logic [3:0] btn;
    logic       bl;
    logic       br;
    int         cyc;
    int         st, go, srv, p1, p2, tm, win;
  } vec_t;

  vec_t tbl [20];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_all(input string tag, input vec_t v);
    check({tag, ".state"},  int'(game_state), v.st);
    check({tag, ".go"},     int'(serve_go),   v.go);
    check({tag, ".server"}, int'(server),     v.srv);
    check({tag, ".p1"},     int'(p1_score),   v.p1);
    check({tag, ".p2"},     int'(p2_score),   v.p2);
    check({tag, ".time"},   int'(time_cnt),   v.tm);
    check({tag, ".winner"}, int'(winner),     v.win);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    {p1l, p1r, p2l, p2r} = 4'b1111;
    ball_out_left = 1'b0; ball_out_right = 1'b0;
    step(1);
    reset = 1'b1;
    step(1);
  endtask

  initial begin
    vec_t rv;
    logic [3:0]  btn;
    logic [19:0] act_v, exp_v;

    // btn = {p1l,p1r,p2l,p2r}; ball pulses last one cycle; then expected outputs
    tbl[0]  = '{4'b1101, 1'b0, 1'b0, 5,  0, 0, 0, 0, 0, 5, 0};
    tbl[1]  = '{4'b1111, 1'b0, 1'b0, 5,  0, 0, 0, 0, 0, 5, 0};
    tbl[2]  = '{4'b1011, 1'b0, 1'b0, 3,  1, 1, 0, 0, 0, 5, 0};
    tbl[3]  = '{4'b1011, 1'b0, 1'b0, 1,  1, 0, 0, 0, 0, 5, 0};
    tbl[4]  = '{4'b1111, 1'b0, 1'b1, 1,  3, 0, 1, 1, 0, 5, 0};
    tbl[5]  = '{4'b1111, 1'b0, 1'b0, 7,  3, 0, 1, 1, 0, 5, 0};
    tbl[6]  = '{4'b1111, 1'b0, 1'b0, 1,  0, 0, 1, 1, 0, 5, 0};
    tbl[7]  = '{4'b0111, 1'b0, 1'b0, 6,  0, 0, 1, 1, 0, 5, 0};
    tbl[8]  = '{4'b1111, 1'b0, 1'b0, 4,  0, 0, 1, 1, 0, 5, 0};
    tbl[9]  = '{4'b1110, 1'b0, 1'b0, 3,  1, 1, 1, 1, 0, 5, 0};
    tbl[10] = '{4'b1111, 1'b1, 1'b1, 1,  1, 0, 1, 1, 0, 5, 0};
    tbl[11] = '{4'b1111, 1'b1, 1'b0, 1,  3, 0, 0, 1, 1, 5, 0};
    tbl[12] = '{4'b1111, 1'b0, 1'b0, 8,  0, 0, 0, 1, 1, 5, 0};
    tbl[13] = '{4'b0111, 1'b0, 1'b0, 3,  1, 1, 0, 1, 1, 5, 0};
    tbl[14] = '{4'b1111, 1'b1, 1'b0, 1,  3, 0, 0, 1, 2, 5, 0};
    tbl[15] = '{4'b1111, 1'b0, 1'b0, 8,  0, 0, 0, 1, 2, 5, 0};
    tbl[16] = '{4'b1011, 1'b0, 1'b0, 3,  1, 1, 0, 1, 2, 5, 0};
    tbl[17] = '{4'b1111, 1'b1, 1'b0, 1,  2, 0, 0, 1, 3, 5, 2};
    tbl[18] = '{4'b0110, 1'b0, 1'b1, 10, 2, 0, 0, 1, 3, 5, 2};
    tbl[19] = '{4'b1111, 1'b0, 1'b0, 6,  2, 0, 0, 1, 3, 5, 2};

    step(2);
    rv = '{4'b1111, 1'b0, 1'b0, 0, 0, 0, 0, 0, 0, 5, 0};
    check_all("reset", rv);
    reset = 1'b1;
    step(2);

    for (int i = 0; i < 20; i++) begin
      {p1l, p1r, p2l, p2r} = tbl[i].btn;
      ball_out_left  = tbl[i].bl;
      ball_out_right = tbl[i].br;
      step(1);
      ball_out_left  = 1'b0;
      ball_out_right = 1'b0;
      if (tbl[i].cyc > 1) step(tbl[i].cyc - 1);
      check_all($sformatf("vec%0d", i), tbl[i]);
    end

    // Time-out at 0-0: one second per TD cycles, tie on expiry, counter holds at 0.
    do_reset();
    p1l = 1'b0;
    step(3);
    check("timeout.serve_go", int'(serve_go), 1);
    p1l = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      step(4);
      check($sformatf("timeout.time%0d", k), int'(time_cnt), 5 - k);
      check($sformatf("timeout.state%0d", k), int'(game_state), (k == 5) ? 2 : 1);
    end
    check("timeout.winner", int'(winner), 3);
    step(8);
    check("timeout.hold_time", int'(time_cnt), 0);
    check("timeout.hold_state", int'(game_state), 2);

    // Reset asserted in the middle of POINT acts without a clock edge.
    do_reset();
    p1l = 1'b0;
    step(3);
    p1l = 1'b1;
    ball_out_right = 1'b1;
    step(1);
    ball_out_right = 1'b0;
    check("midpoint.state_before", int'(game_state), 3);
    step(2);
    reset = 1'b0;
    #2;
    check("midpoint.state", int'(game_state), 0);
    check("midpoint.p1", int'(p1_score), 0);
    check("midpoint.time", int'(time_cnt), 5);
    check("midpoint.server", int'(server), 0);
    step(1);
    reset = 1'b1;
    step(1);
`ifdef MATCH_AUTO_SERVE_EN
    step(18);
    check("auto.wait_state", int'(game_state), 0);
    step(1);
    check("auto.state", int'(game_state), 1);
    check("auto.serve_go", int'(serve_go), 1);
`else
    step(30);
    check("noauto.state", int'(game_state), 0);
    check("noauto.serve_go", int'(serve_go), 0);
`endif

    // Random run compared every cycle against the reference model.
    do_reset();
    btn = 4'b1111;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(5) == 0) begin
        int b;
        b = int'($urandom_range(3));
        btn[b] = ~btn[b];
      end
      {p1l, p1r, p2l, p2r} = btn;
      ball_out_left  = ($urandom_range(9) == 0);
      ball_out_right = ($urandom_range(9) == 0);
      if ($urandom_range(149) == 0) reset = 1'b0;
      step(1);
      ball_out_left  = 1'b0;
      ball_out_right = 1'b0;
      reset = 1'b1;
      act_v = {game_state, server, serve_go, p1_score, p2_score, time_cnt, winner};
      exp_v = {2'(m_st), 1'(m_srv), 1'(m_go), 4'(m_p1), 4'(m_p2), 6'(m_tm), 2'(m_win)};
      checks++;
      if (act_v !== exp_v) begin
        failures++;
        $display("FAIL rand%0d actual=%h required=%h", i, act_v, exp_v);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/match_controller.md
Name: match_controller

Overview:
Central sequencer for the ping-pong game. It owns the match state machine (serve / playing / point pause / done), decides which player serves, keeps both scores and runs the countdown timer. It drives game_state to the board controller, ball logic and the displayers, and takes point-scored pulses back from the ball datapath.

Parameters:
TICK_DIV, 50000000, clk cycles per 1 s timer tick (benches override with a small value)
MATCH_SECONDS, 60, initial time_cnt value; must be 63 or less
WIN_SCORE, 7, score that ends the match; must be 15 or less
PAUSE_TICKS, 2, ticks spent in POINT before returning to SERVE
SERVE_TIMEOUT, 5, ticks before an automatic serve (used only with the optional feature)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset
p1l  in  1  player 1 button, active-low, asynchronous to clk
p1r  in  1  player 1 button, active-low
p2l  in  1  player 2 button, active-low
p2r  in  1  player 2 button, active-low
ball_out_left  in  1  one-cycle pulse: ball passed player 1's edge, point to player 2
ball_out_right  in  1  one-cycle pulse: ball passed player 2's edge, point to player 1
game_state  out  2  0=SERVE, 1=PLAY, 2=DONE, 3=POINT
server  out  1  0=player 1 serves, 1=player 2 serves
serve_go  out  1  one-cycle pulse that launches the ball
p1_score  out  4  player 1 points
p2_score  out  4  player 2 points
time_cnt  out  6  seconds remaining
winner  out  2  0=none, 1=player 1, 2=player 2, 3=tie; valid in DONE

Behaviour:
- Reset is asynchronous and active-low and takes effect at any time, including mid-point. It forces:
  - game_state=SERVE, server=0, serve_go=0
  - both scores 0, time_cnt=MATCH_SECONDS, winner=0
  - tick counter 0, synchroniser flops 1
- Buttons: each passes through a 2-flop synchroniser, then a falling-edge (press) detector. A press is seen 3 cycles after the pin falls. Holding a button produces exactly one press.
- Tick counter:
  - Counts 0..TICK_DIV-1 in PLAY, POINT and (with the option) SERVE.
  - Produces a one-cycle tick on wrap.
  - Is cleared on every state change.
- SERVE:
  - A press of either of the server's buttons asserts serve_go for one cycle and moves to PLAY on the same edge.
  - Presses from the non-server are ignored.
  - Timer is frozen.
- PLAY:
  - Each tick decrements time_cnt; time_cnt saturates at 0.
  - ball_out_right alone: p1_score+1, server=1 (the loser serves), go to POINT.
  - ball_out_left alone: p2_score+1, server=0, go to POINT.
  - Both pulses in the same cycle: no score, stay in PLAY.
  - The incremented score reaches WIN_SCORE: go to DONE instead of POINT.
  - time_cnt becomes 0 on a tick: go to DONE.
  - Score and time-out in the same cycle: the score is applied first, then DONE.
- POINT:
  - After PAUSE_TICKS ticks, go to SERVE.
  - time_cnt does not decrement.
  - ball_out pulses and buttons are ignored.
- DONE:
  - winner is registered on entry by comparing the scores (>, <, =).
  - All outputs hold until reset; every input is ignored.
- Scores never exceed WIN_SCORE.
- All outputs are registered. serve_go is the only pulse output.

Optional Feature:
MATCH_AUTO_SERVE_EN
- Defined:
  - In SERVE the tick counter runs.
  - After SERVE_TIMEOUT ticks with no valid press, serve_go pulses and the state goes to PLAY exactly as for a press.
  - A press arriving in the same cycle as the timeout gives a single serve_go.
- Undefined: SERVE waits forever; SERVE_TIMEOUT is unused.

Decomposition:
- Shared package (ping_pong_pkg):
  - game_state encodings SERVE=2'd0, PLAY=2'd1, DONE=2'd2, POINT=2'd3
  - winner encodings
  - default constants WIN_SCORE, MATCH_SECONDS
- The board controller, ball logic and displayers import this package so they share one encoding.
- One sub-module, button_press_sync: 2-flop synchroniser plus falling-edge detect, instanced four times.

Test Plan:
All scenarios use TICK_DIV=4, MATCH_SECONDS=5, WIN_SCORE=3, PAUSE_TICKS=2.
1. Release reset, press p2l -> no serve_go, state stays 0. Press p1r -> serve_go high 1 cycle 3 cycles later, state=1.
2. In PLAY, ball_out_right pulse -> p1_score=1, server=1, state=3. After 8 cycles state=0. Only a p2 press now serves.
3. ball_out_left and ball_out_right in the same cycle -> scores unchanged, state stays 1.
4. p2 scores 3 times -> state=2, p2_score=3, winner=2. Further presses and pulses change nothing.
5. Serve, then idle 20 cycles -> time_cnt steps 5..0, state=2, winner=3 at 0-0. Time_cnt holds at 0.
6. Assert reset mid-POINT -> next sample shows state=0, scores 0, time_cnt=5, server=0. With MATCH_AUTO_SERVE_EN, idle 20 cycles in SERVE -> serve_go pulses and state=1.
